period_gen: RTL and testbench

PERIOD_GEN -- requirements
Module: period_gen

---
 rtl/period_gen.sv | 146 ++++++++++++++
 tb/tb_period_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/period_gen.sv
// ============================================================================
// Module   : period_gen
// Brief    : Periodic waveform generator with a double-buffered period/high
//            setting applied only on period boundaries. Optional macro
//            PERIOD_CLAMP_EN clamps out-of-range loads instead of rejecting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module period_gen #(
    parameter int CNT_W      = 8,
    parameter int MIN_PERIOD = 6
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             en_in,
    input  logic             load_in,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] high_in,
    output logic             load_ack_out,
    output logic             err_out,
    output logic             busy_out,
    output logic             y_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    localparam logic [CNT_W-1:0] c_MIN_PER = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] c_DEF_HI  = CNT_W'(MIN_PERIOD / 2);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_act_per;
    logic [CNT_W-1:0] r_act_hi;
    logic [CNT_W-1:0] r_pnd_per;
    logic [CNT_W-1:0] r_pnd_hi;
    logic             r_pnd_v;
    logic             r_y;
    logic             r_ack;
    logic             r_err;

    logic [CNT_W-1:0] w_ld_per;
    logic [CNT_W-1:0] w_ld_hi;
    logic             w_ld_ok;
    logic [CNT_W-1:0] w_nxt_per;
    logic [CNT_W-1:0] w_nxt_hi;
    logic             w_start;

`ifdef PERIOD_CLAMP_EN
    always_comb begin
        w_ld_per = (period_in < c_MIN_PER) ? c_MIN_PER : period_in;
        if (high_in == '0) begin
            w_ld_hi = c_ONE;
        end else if (high_in >= w_ld_per) begin
            w_ld_hi = w_ld_per - c_ONE;
        end else begin
            w_ld_hi = high_in;
        end
        w_ld_ok = 1'b1;
    end
`else
    always_comb begin
        w_ld_per = period_in;
        w_ld_hi  = high_in;
        w_ld_ok  = (period_in >= c_MIN_PER) && (high_in != '0) &&
                   (high_in < period_in);
    end
`endif

    // Setting that takes effect if a new period starts this cycle.
    assign w_nxt_per = r_pnd_v ? r_pnd_per : r_act_per;
    assign w_nxt_hi  = r_pnd_v ? r_pnd_hi  : r_act_hi;

    // A period starts from IDLE, or at the end of LOW when still enabled.
    assign w_start = en_in && ((r_state == S_IDLE) ||
                               ((r_state == S_LOW) && (r_cnt == '0)));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_act_per <= c_MIN_PER;
            r_act_hi  <= c_DEF_HI;
            r_pnd_per <= '0;
            r_pnd_hi  <= '0;
            r_pnd_v   <= 1'b0;
            r_y       <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ack <= load_in && w_ld_ok;
            r_err <= load_in && !w_ld_ok;

            if (w_start) begin
                r_act_per <= w_nxt_per;
                r_act_hi  <= w_nxt_hi;
                r_cnt     <= w_nxt_hi - c_ONE;
                r_pnd_v   <= 1'b0;
                r_state   <= S_HIGH;
                r_y       <= 1'b1;
            end else begin
                case (r_state)
                    S_HIGH: begin
                        if (r_cnt == '0) begin
                            r_cnt   <= r_act_per - r_act_hi - c_ONE;
                            r_state <= S_LOW;
                            r_y     <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - c_ONE;
                        end
                    end
                    S_LOW: begin
                        if (r_cnt == '0) begin
                            r_state <= S_IDLE;
                            r_y     <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - c_ONE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_y     <= 1'b0;
                    end
                endcase
            end

            // A same-cycle load wins over the boundary's clear of pnd_v.
            if (load_in && w_ld_ok) begin
                r_pnd_per <= w_ld_per;
                r_pnd_hi  <= w_ld_hi;
                r_pnd_v   <= 1'b1;
            end
        end
    end

    assign load_ack_out = r_ack;
    assign err_out      = r_err;
    assign busy_out     = (r_state != S_IDLE);
    assign y_out        = r_y;

endmodule

`default_nettype wire

// File: tb/tb_period_gen.sv
// ============================================================================
// Module   : tb_period_gen
// Brief    : Directed self-checking bench for period_gen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_period_gen;

    logic       clk_in;
    logic       rst_n_in;
    logic       en_in;
    logic       load_in;
    logic [7:0] period_in;
    logic [7:0] high_in;
    logic       load_ack_out;
    logic       err_out;
    logic       busy_out;
    logic       y_out;

    int n_checks = 0;
    int n_pass   = 0;

    period_gen #(.CNT_W(8), .MIN_PERIOD(6)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .en_in        (en_in),
        .load_in      (load_in),
        .period_in    (period_in),
        .high_in      (high_in),
        .load_ack_out (load_ack_out),
        .err_out      (err_out),
        .busy_out     (busy_out),
        .y_out        (y_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Advance until y_out rises; ok=0 if it never does.
    task automatic wait_rise(output int ok);
        logic prev;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            prev = y_out;
            tick();
            if (!prev && y_out) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Called at the first high sample; returns at the next rise.
    task automatic measure(output int hi, output int lo);
        hi = 0;
        lo = 0;
        while (y_out && hi < 300) begin
            hi++;
            tick();
        end
        while (!y_out && lo < 300) begin
            lo++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; en_in = 1'b0; load_in = 1'b0;
        period_in = '0; high_in = '0;
        tick(); tick();
        n_checks++; if (y_out !== 1'b0) $display("FAIL reset_y got=%b exp=0", y_out); else n_pass++;
        n_checks++; if (busy_out !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_out); else n_pass++;
        n_checks++; if (load_ack_out !== 1'b0) $display("FAIL reset_ack got=%b exp=0", load_ack_out); else n_pass++;
        n_checks++; if (err_out !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_out); else n_pass++;
        rst_n_in = 1'b1;
        tick();
    endtask

    task automatic test_default();
        int hi, lo;
        en_in = 1'b1;
        tick();
        n_checks++; if (y_out !== 1'b1) $display("FAIL start_y got=%b exp=1", y_out); else n_pass++;
        n_checks++; if (busy_out !== 1'b1) $display("FAIL start_busy got=%b exp=1", busy_out); else n_pass++;
        for (int p = 0; p < 2; p++) begin
            measure(hi, lo);
            n_checks++; if (hi !== 3) $display("FAIL default_hi[%0d] got=%0d exp=3", p, hi); else n_pass++;
            n_checks++; if (lo !== 3) $display("FAIL default_lo[%0d] got=%0d exp=3", p, lo); else n_pass++;
        end
    endtask

    task automatic test_load_running();
        int hi, lo, cyc, acks;
        load_in = 1'b1; period_in = 8'd10; high_in = 8'd4;
        tick();
        load_in = 1'b0;
        n_checks++; if (load_ack_out !== 1'b1) $display("FAIL load_ack got=%b exp=1", load_ack_out); else n_pass++;
        cyc = 0; acks = 0;
        while (!(y_out && cyc > 2) && cyc < 300) begin
            tick();
            cyc++;
            if (load_ack_out) acks++;
        end
        n_checks++; if (acks !== 0) $display("FAIL load_ack_extra got=%0d exp=0", acks); else n_pass++;
        n_checks++; if (cyc !== 5) $display("FAIL load_old_period_rest got=%0d exp=5", cyc); else n_pass++;
        measure(hi, lo);
        n_checks++; if (hi !== 4) $display("FAIL load_hi got=%0d exp=4", hi); else n_pass++;
        n_checks++; if (lo !== 6) $display("FAIL load_lo got=%0d exp=6", lo); else n_pass++;
    endtask

    task automatic test_illegal_load();
        int hi, lo, ok;
        load_in = 1'b1; period_in = 8'd4; high_in = 8'd2;
        tick();
        load_in = 1'b0;
`ifdef PERIOD_CLAMP_EN
        n_checks++; if (load_ack_out !== 1'b1) $display("FAIL clamp_ack got=%b exp=1", load_ack_out); else n_pass++;
        n_checks++; if (err_out !== 1'b0) $display("FAIL clamp_err got=%b exp=0", err_out); else n_pass++;
        wait_rise(ok);
        measure(hi, lo);
        n_checks++; if (hi !== 2) $display("FAIL clamp_hi got=%0d exp=2", hi); else n_pass++;
        n_checks++; if (lo !== 4) $display("FAIL clamp_lo got=%0d exp=4", lo); else n_pass++;
`else
        n_checks++; if (err_out !== 1'b1) $display("FAIL illegal_err got=%b exp=1", err_out); else n_pass++;
        n_checks++; if (load_ack_out !== 1'b0) $display("FAIL illegal_ack got=%b exp=0", load_ack_out); else n_pass++;
        wait_rise(ok);
        measure(hi, lo);
        n_checks++; if (hi !== 4) $display("FAIL illegal_hi got=%0d exp=4", hi); else n_pass++;
        n_checks++; if (lo !== 6) $display("FAIL illegal_lo got=%0d exp=6", lo); else n_pass++;
`endif
        n_checks++; if (ok !== 1) $display("FAIL illegal_rise_timeout got=%0d exp=1", ok); else n_pass++;
    endtask

    task automatic test_en_drop();
        int ok, cyc, highs;
        load_in = 1'b1; period_in = 8'd10; high_in = 8'd4;
        tick();
        load_in = 1'b0;
        wait_rise(ok);
        tick();
        en_in = 1'b0;
        cyc = 0; highs = 0;
        while (busy_out && cyc < 300) begin
            tick();
            cyc++;
            if (y_out) highs++;
        end
        n_checks++; if (cyc !== 9) $display("FAIL drop_cycles got=%0d exp=9", cyc); else n_pass++;
        n_checks++; if (highs !== 2) $display("FAIL drop_high_rest got=%0d exp=2", highs); else n_pass++;
        n_checks++; if (y_out !== 1'b0) $display("FAIL drop_y got=%b exp=0", y_out); else n_pass++;
        tick(); tick(); tick();
        n_checks++; if (busy_out !== 1'b0) $display("FAIL drop_idle_busy got=%b exp=0", busy_out); else n_pass++;
        n_checks++; if (y_out !== 1'b0) $display("FAIL drop_idle_y got=%b exp=0", y_out); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int hi, lo, ok;
        en_in = 1'b1;
        tick();
        repeat (5) tick();
        n_checks++; if (y_out !== 1'b0 || busy_out !== 1'b1) $display("FAIL mid_low_state got=%b%b exp=01", y_out, busy_out); else n_pass++;
        #2 rst_n_in = 1'b0;
        #1;
        n_checks++; if (y_out !== 1'b0) $display("FAIL async_rst_y got=%b exp=0", y_out); else n_pass++;
        n_checks++; if (busy_out !== 1'b0) $display("FAIL async_rst_busy got=%b exp=0", busy_out); else n_pass++;
        #1 rst_n_in = 1'b1;
        wait_rise(ok);
        measure(hi, lo);
        n_checks++; if (hi !== 3 || lo !== 3) $display("FAIL post_rst_wave got=%0d/%0d exp=3/3", hi, lo); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int hi, lo, ok, acks;
        acks = 0;
        load_in = 1'b1; period_in = 8'd8; high_in = 8'd2;
        tick();
        if (load_ack_out) acks++;
        period_in = 8'd12; high_in = 8'd5;
        tick();
        if (load_ack_out) acks++;
        load_in = 1'b0;
        tick();
        if (load_ack_out) acks++;
        n_checks++; if (acks !== 2) $display("FAIL b2b_acks got=%0d exp=2", acks); else n_pass++;
        wait_rise(ok);
        measure(hi, lo);
        n_checks++; if (hi !== 5) $display("FAIL b2b_hi got=%0d exp=5", hi); else n_pass++;
        n_checks++; if (lo !== 7) $display("FAIL b2b_lo got=%0d exp=7", lo); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_default();
        test_load_running();
        test_illegal_load();
        test_en_drop();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
